// File: rtl/fifo_stream_reader.sv
// Drains a non-showahead pixel FIFO into a valid/ready stream framed with sop/eop; 2-cycle first-beat latency, 1 beat/cycle sustained.
// Backpressure: 2-entry output buffer, FIFO reads throttled by occupancy + in-flight. Optional src_eol via `FIFO_STREAM_READER_EOL_EN.
module fifo_stream_reader #(
    parameter int DWIDTH = 24,
    parameter int DIMW   = 11
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              fifo_empty,
    input  logic [DWIDTH-1:0] fifo_q,
    output logic              fifo_rdreq,
    input  logic              cfg_valid,
    input  logic [DIMW-1:0]   cfg_width,
    input  logic [DIMW-1:0]   cfg_height,
    output logic [DWIDTH-1:0] src_data,
    output logic              src_valid,
    input  logic              src_ready,
    output logic              src_sop,
    output logic              src_eop,
`ifdef FIFO_STREAM_READER_EOL_EN
    output logic              src_eol,
`endif
    output logic              busy,
    output logic              frame_done
);

    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

    state_t              state_q, state_d;
    logic                latch_cfg;
    logic [DIMW-1:0]     width_q, height_q;
    logic [DIMW-1:0]     x_q, y_q;
    logic [2*DIMW-1:0]   req_cnt_q, total;
    logic                inflight_q;
    logic [DWIDTH-1:0]   buf_mem [2];
    logic                wr_ptr_q, rd_ptr_q;
    logic [1:0]          occ_q;
    logic                pop, push, last_x, last_y;
    logic [2:0]          occ_net;

    assign total     = {{DIMW{1'b0}}, width_q} * {{DIMW{1'b0}}, height_q};
    assign push      = inflight_q;
    assign src_valid = (occ_q != 2'd0);
    assign pop       = src_valid & src_ready;
    assign src_data  = buf_mem[rd_ptr_q];
    assign last_x    = (x_q == width_q - DIMW'(1));
    assign last_y    = (y_q == height_q - DIMW'(1));
    assign src_sop   = src_valid && (x_q == '0) && (y_q == '0);
    assign src_eop   = src_valid && last_x && last_y;
`ifdef FIFO_STREAM_READER_EOL_EN
    assign src_eol   = src_valid && last_x;
`endif
    assign busy       = (state_q != IDLE);
    assign frame_done = (state_q == DONE);

    // Occupancy the buffer will reach once everything already requested has landed.
    assign occ_net    = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign fifo_rdreq = (state_q == STREAM) && !fifo_empty &&
                        (req_cnt_q < total) && (occ_net < 3'd2);

    always_comb begin
        state_d   = state_q;
        latch_cfg = 1'b0;
        case (state_q)
            IDLE: begin
                if (cfg_valid && (cfg_width != '0) && (cfg_height != '0)) begin
                    state_d   = STREAM;
                    latch_cfg = 1'b1;
                end
            end
            STREAM: begin
                if (pop && src_eop) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            width_q    <= '0;
            height_q   <= '0;
            req_cnt_q  <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            inflight_q <= fifo_rdreq;
            if (latch_cfg) begin
                width_q   <= cfg_width;
                height_q  <= cfg_height;
                req_cnt_q <= '0;
            end else if (fifo_rdreq) begin
                req_cnt_q <= req_cnt_q + (2*DIMW)'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                buf_mem[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            if (push) begin
                buf_mem[wr_ptr_q] <= fifo_q;
                wr_ptr_q          <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            occ_q <= occ_q + {1'b0, push} - {1'b0, pop};
        end
    end

    // Position of the head beat; only moves when that beat is accepted.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            x_q <= '0;
            y_q <= '0;
        end else if (pop) begin
            if (last_x) begin
                x_q <= '0;
                y_q <= last_y ? '0 : y_q + DIMW'(1);
            end else begin
                x_q <= x_q + DIMW'(1);
            end
        end
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader: cycle table for a 4x2 frame plus stall, FIFO-gap, 1x1, zero-dim and mid-frame reset sequences.
module tb_fifo_stream_reader;

    localparam int DW = 24;
    localparam int DM = 11;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          fifo_empty;
    logic [DW-1:0] fifo_q = '0;
    logic          fifo_rdreq;
    logic          cfg_valid = 1'b0;
    logic [DM-1:0] cfg_width = '0;
    logic [DM-1:0] cfg_height = '0;
    logic [DW-1:0] src_data;
    logic          src_valid;
    logic          src_ready = 1'b0;
    logic          src_sop;
    logic          src_eop;
`ifdef FIFO_STREAM_READER_EOL_EN
    logic          src_eol;
`endif
    logic          busy;
    logic          frame_done;

    logic          force_empty = 1'b0;
    logic [DW-1:0] fifo_mem [256];
    int            wr_idx = 0;
    int            rd_idx = 0;
    int            exp_idx = 0;
    int            n_cmp = 0;
    int            n_bad = 0;

    fifo_stream_reader #(.DWIDTH(DW), .DIMW(DM)) dut (
        .clock      (clock),
        .reset      (reset),
        .fifo_empty (fifo_empty),
        .fifo_q     (fifo_q),
        .fifo_rdreq (fifo_rdreq),
        .cfg_valid  (cfg_valid),
        .cfg_width  (cfg_width),
        .cfg_height (cfg_height),
        .src_data   (src_data),
        .src_valid  (src_valid),
        .src_ready  (src_ready),
        .src_sop    (src_sop),
        .src_eop    (src_eop),
`ifdef FIFO_STREAM_READER_EOL_EN
        .src_eol    (src_eol),
`endif
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clock = ~clock;

    // Non-showahead FIFO model: data appears on fifo_q the edge after the request.
    assign fifo_empty = force_empty || (rd_idx == wr_idx);
    always @(posedge clock) begin
        if (fifo_rdreq && (rd_idx != wr_idx)) begin
            fifo_q <= fifo_mem[8'(rd_idx)];
            rd_idx <= rd_idx + 1;
        end
    end

    typedef struct {
        logic          ready;
        logic          rdreq;
        logic          valid;
        logic [DW-1:0] data;
        logic          sop;
        logic          eop;
        logic          done;
        logic          busy;
    } vec_t;

    vec_t vecs [12];

    function automatic vec_t mk(input logic r, input logic rq, input logic v, input logic [DW-1:0] d,
                                input logic s, input logic e, input logic dn, input logic b);
        vec_t t;
        t.ready = r; t.rdreq = rq; t.valid = v; t.data = d;
        t.sop = s; t.eop = e; t.done = dn; t.busy = b;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic push_word(input logic [DW-1:0] d);
        fifo_mem[8'(wr_idx)] = d;
        wr_idx++;
    endtask

    function automatic logic [31:0] out_flags();
        return 32'({fifo_rdreq, src_valid, src_sop, src_eop, busy, frame_done});
    endfunction

    task automatic run_frame(input int w, input int h, input bit toggle, input int gap_after, input string tag);
        int total, beats, issued, max_out, gap_left, eop_cyc;
        bit done_seen, gap_used, saw_drop, prev_stall, prev_sop, prev_eop;
        logic [DW-1:0] prev_d;
        total = w * h; beats = 0; issued = 0; max_out = 0; gap_left = 0; eop_cyc = -10;
        done_seen = 0; gap_used = 0; saw_drop = 0; prev_stall = 0; prev_sop = 0; prev_eop = 0; prev_d = '0;
        @(negedge clock);
        cfg_valid = 1'b1; cfg_width = DM'(w); cfg_height = DM'(h);
        for (int cyc = 0; cyc < 200 && !done_seen; cyc++) begin
            @(negedge clock);
            cfg_valid = 1'b0;
            src_ready = toggle ? ((cyc % 2) == 0) : 1'b1;
            if (gap_after >= 0 && !gap_used && beats == gap_after) begin
                gap_used = 1; gap_left = 5;
            end
            force_empty = (gap_left > 0);
            #1;
            check({tag, "_rdreq_vs_empty"}, 32'(fifo_rdreq & fifo_empty), 32'd0);
            if (prev_stall)
                check({tag, "_stall_hold"}, 32'({src_valid, src_data, src_sop, src_eop}),
                      32'({1'b1, prev_d, prev_sop, prev_eop}));
            if (gap_left > 0 && !src_valid) saw_drop = 1;
            if (fifo_rdreq) issued++;
            if (src_valid && src_ready) begin
                check({tag, "_data"}, 32'(src_data), 32'(fifo_mem[8'(exp_idx + beats)]));
                check({tag, "_sop"}, 32'(src_sop), 32'(beats == 0));
                check({tag, "_eop"}, 32'(src_eop), 32'(beats == total - 1));
`ifdef FIFO_STREAM_READER_EOL_EN
                check({tag, "_eol"}, 32'(src_eol), 32'((beats % w) == w - 1));
`endif
                if (beats == total - 1) eop_cyc = cyc;
                beats++;
            end
            if (issued - beats > max_out) max_out = issued - beats;
            if (frame_done) begin
                done_seen = 1;
                check({tag, "_done_timing"}, 32'(cyc), 32'(eop_cyc + 1));
                check({tag, "_beat_count"}, 32'(beats), 32'(total));
            end
            prev_stall = src_valid && !src_ready;
            prev_d = src_data; prev_sop = src_sop; prev_eop = src_eop;
            if (gap_left > 0) gap_left--;
        end
        check({tag, "_frame_done_seen"}, 32'(done_seen), 32'd1);
        check({tag, "_outstanding_le2"}, 32'(max_out <= 2), 32'd1);
        if (gap_after >= 0) check({tag, "_valid_drop_in_gap"}, 32'(saw_drop), 32'd1);
        @(negedge clock);
        force_empty = 1'b0;
        #1;
        check({tag, "_idle_after"}, 32'(busy), 32'd0);
        check({tag, "_words_read"}, 32'(rd_idx), 32'(exp_idx + total));
        exp_idx += total;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int beats;
        for (int i = 1; i <= 8; i++) push_word(DW'(i));
        push_word(24'h000099);

        vecs[0]  = mk(1'b1, 1'b1, 1'b0, 24'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        vecs[1]  = mk(1'b1, 1'b1, 1'b0, 24'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        vecs[2]  = mk(1'b1, 1'b1, 1'b1, 24'd1, 1'b1, 1'b0, 1'b0, 1'b1);
        vecs[3]  = mk(1'b1, 1'b1, 1'b1, 24'd2, 1'b0, 1'b0, 1'b0, 1'b1);
        vecs[4]  = mk(1'b1, 1'b1, 1'b1, 24'd3, 1'b0, 1'b0, 1'b0, 1'b1);
        vecs[5]  = mk(1'b1, 1'b1, 1'b1, 24'd4, 1'b0, 1'b0, 1'b0, 1'b1);
        vecs[6]  = mk(1'b1, 1'b1, 1'b1, 24'd5, 1'b0, 1'b0, 1'b0, 1'b1);
        vecs[7]  = mk(1'b1, 1'b1, 1'b1, 24'd6, 1'b0, 1'b0, 1'b0, 1'b1);
        vecs[8]  = mk(1'b1, 1'b0, 1'b1, 24'd7, 1'b0, 1'b0, 1'b0, 1'b1);
        vecs[9]  = mk(1'b1, 1'b0, 1'b1, 24'd8, 1'b0, 1'b1, 1'b0, 1'b1);
        vecs[10] = mk(1'b1, 1'b0, 1'b0, 24'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        vecs[11] = mk(1'b1, 1'b0, 1'b0, 24'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        @(negedge clock);
        #1;
        check("reset_flags", out_flags(), 32'd0);
        check("reset_data", 32'(src_data), 32'd0);
        reset = 1'b0;

        // 4x2 frame, ready held high: cycle-exact expectations.
        @(negedge clock);
        cfg_valid = 1'b1; cfg_width = DM'(4); cfg_height = DM'(2);
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            cfg_valid = 1'b0;
            src_ready = vecs[i].ready;
            #1;
            check($sformatf("vec%0d", i),
                  32'({fifo_rdreq, src_valid, src_sop, src_eop, frame_done, busy, src_valid ? src_data : 24'd0}),
                  32'({vecs[i].rdreq, vecs[i].valid, vecs[i].sop, vecs[i].eop, vecs[i].done, vecs[i].busy,
                       vecs[i].valid ? vecs[i].data : 24'd0}));
        end
        check("tail_unread", 32'(rd_idx), 32'd8);
        exp_idx = 8;

        for (int i = 1; i <= 7; i++) push_word(24'h000030 + DW'(i));
        run_frame(4, 2, 1'b1, -1, "stall");

        for (int i = 1; i <= 8; i++) push_word(24'h000040 + DW'(i));
        run_frame(4, 2, 1'b0, 3, "gap");

        push_word(24'hABCDEF);
        run_frame(1, 1, 1'b0, -1, "one");

        // Zero width must be ignored even with data waiting.
        push_word(24'h000055);
        @(negedge clock);
        cfg_valid = 1'b1; cfg_width = DM'(0); cfg_height = DM'(3);
        @(negedge clock);
        cfg_valid = 1'b0;
        #1;
        check("zero_dim_busy", 32'(busy), 32'd0);
        check("zero_dim_rdreq", 32'(fifo_rdreq), 32'd0);
        @(negedge clock);
        #1;
        check("zero_dim_unread", 32'(rd_idx), 32'(exp_idx));

        // Reset after beat 3 of a 4x2 frame.
        for (int i = 1; i <= 7; i++) push_word(24'h000020 + DW'(i));
        @(negedge clock);
        cfg_valid = 1'b1; cfg_width = DM'(4); cfg_height = DM'(2);
        beats = 0;
        for (int cyc = 0; cyc < 50 && beats < 3; cyc++) begin
            @(negedge clock);
            cfg_valid = 1'b0;
            src_ready = 1'b1;
            #1;
            if (src_valid && src_ready) beats++;
        end
        check("rst_pre_beats", 32'(beats), 32'd3);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("rst_async_flags", out_flags(), 32'd0);
        @(negedge clock);
        #1;
        check("rst_next_flags", out_flags(), 32'd0);
        check("rst_next_data", 32'(src_data), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        check("rst_reads_consumed", 32'(rd_idx), 32'(exp_idx + 5));
        check("rst_stays_idle", 32'(busy), 32'd0);
        exp_idx += 5;
        check("restart_head_word", 32'(fifo_mem[8'(exp_idx)]), 32'h000025);
        run_frame(3, 1, 1'b0, -1, "restart");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
